if_prefetch: RTL and testbench

IF_PREFETCH -- requirements
Module: if_prefetch

---
 rtl/riscv_pkg.sv | 19 +
 rtl/if_prefetch_if.sv | 29 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/if_prefetch.sv | 96 +++++++++
 tb/tb_if_prefetch.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants and types.
//   XLEN / ILEN       : address and instruction widths
//   RESET_PC_DEFAULT  : default first fetch address
//   fetch_pair_t      : {pc, instr} pair held in the instruction buffer
//   word_align()      : clears the two low address bits
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_pair_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/if_prefetch_if.sv
// Fetch-unit bundle: redirect input, instruction-memory request/response
// channel and the decode-side valid/ready channel.
//   master : the prefetcher (drives imem_req/imem_addr and if_*)
//   slave  : the environment (memory, decode, branch unit)
interface if_prefetch_if;
  import riscv_pkg::*;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [ILEN-1:0] if_instr;
  logic            if_ready;

  modport master (
    input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    output imem_req, imem_addr, if_valid, if_pc, if_instr
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    input  imem_req, imem_addr, if_valid, if_pc, if_instr
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO, first-word-fall-through read port.
//   clk, reset(async low)
//   flush       : empties the FIFO, wins over push/pop
//   push, din   : write (ignored when full)
//   pop, dout   : read (ignored when empty); dout is the head entry
//   full, empty, count
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [AW:0]      cnt;
  logic             wr, rd;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign dout  = mem[rp];
  assign wr    = push & ~full;
  assign rd    = pop & ~empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (rd) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end

  // Storage needs no reset: nothing is read out until count says so.
  always_ff @(posedge clk)
    if (wr && !flush) mem[wp] <= din;
endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetcher.
//   clk, reset(async low)
//   bus.redirect_*        : flush and restart at a new PC
//   bus.imem_req/addr/gnt : request channel, in-order responses on rvalid/rdata
//   bus.if_valid/pc/instr : head of the instruction buffer, popped on if_ready
// Requests are credit-limited so every live response has a buffer slot.
// Responses to requests in flight at a redirect are counted in `discard`
// and dropped as they return.
module if_prefetch
  import riscv_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
)(
  input  logic          clk,
  input  logic          reset,
  if_prefetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef logic [CW-1:0] cnt_t;

  logic [XLEN-1:0] fetch_pc, redir_pc;
  cnt_t            outst, discard, occ;
  logic [CW:0]     inflight;
  logic            issue, rsp_discard, rsp_live, push, pop;
  logic            fifo_full, fifo_empty;
  fetch_pair_t     din, head;

  // PC queue: one entry per live outstanding request, oldest at rd pointer.
  logic [XLEN-1:0] pcq [DEPTH];
  logic [AW-1:0]   pcq_wp, pcq_rp;

  assign redir_pc    = word_align(bus.redirect_pc);
  assign issue       = bus.imem_req & bus.imem_gnt;
  // Responses are in order, so discarded ones always come back first.
  assign rsp_discard = bus.imem_rvalid & (discard != '0);
  assign rsp_live    = bus.imem_rvalid & (discard == '0) & (outst != '0);
  assign push        = rsp_live & ~bus.redirect_valid;
  assign pop         = bus.if_valid & bus.if_ready & ~bus.redirect_valid;

  assign inflight      = (CW+1)'(occ) + (CW+1)'(outst) + (CW+1)'(discard);
  assign bus.imem_req  = reset & ~fifo_full & (inflight < (CW+1)'(DEPTH));
  // The redirect target goes straight out so a request can issue this cycle.
  assign bus.imem_addr = (reset && bus.redirect_valid) ? redir_pc : fetch_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      outst    <= '0;
      discard  <= '0;
      pcq_wp   <= '0;
      pcq_rp   <= '0;
    end else if (bus.redirect_valid) begin
      // Everything in flight, including a grant this cycle, becomes discard;
      // an rvalid this cycle retires one of them.
      fetch_pc <= redir_pc;
      outst    <= '0;
      discard  <= discard + outst + cnt_t'(issue) - cnt_t'(rsp_discard | rsp_live);
      pcq_wp   <= '0;
      pcq_rp   <= '0;
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + XLEN'(4);
        pcq_wp   <= pcq_wp + AW'(1);
      end
      if (rsp_live) pcq_rp <= pcq_rp + AW'(1);
      outst   <= outst + cnt_t'(issue) - cnt_t'(rsp_live);
      discard <= discard - cnt_t'(rsp_discard);
    end
  end

  always_ff @(posedge clk)
    if (issue && !bus.redirect_valid) pcq[pcq_wp] <= fetch_pc;

  assign din.pc    = pcq[pcq_rp];
  assign din.instr = bus.imem_rdata;

  sync_fifo #(.WIDTH($bits(fetch_pair_t)), .DEPTH(DEPTH)) u_ibuf (
    .clk   (clk),
    .reset (reset),
    .flush (bus.redirect_valid),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occ)
  );

  // Zero the outputs when empty so reset and idle values are clean.
  assign bus.if_valid = ~fifo_empty;
  assign bus.if_pc    = fifo_empty ? '0 : head.pc;
  assign bus.if_instr = fifo_empty ? '0 : head.instr;
endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: streaming fetch, back-pressure credit limit,
// redirect with outstanding/simultaneous traffic, grant stalls with PC wrap,
// and asynchronous reset mid-operation.
module tb_if_prefetch;
  logic clk = 1'b0;
  logic reset;
  int   total = 0, passes = 0, n_issued = 0;
  logic auto_rsp = 1'b0;

  if_prefetch_if b();

  if_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] ins(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock: sample the request handshake mid-cycle, then after the edge
  // optionally play a one-cycle-latency memory response for it.
  task automatic tick();
    logic        p;
    logic [31:0] a;
    @(negedge clk);
    p = b.imem_req & b.imem_gnt;
    a = b.imem_addr;
    @(posedge clk);
    #1;
    if (p) n_issued++;
    if (auto_rsp) begin
      b.imem_rvalid = p;
      b.imem_rdata  = p ? ins(a) : 32'h0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    b.redirect_valid = 1'b0;
    b.redirect_pc = 32'h0;
    b.imem_gnt = 1'b0;
    b.imem_rvalid = 1'b0;
    b.imem_rdata = 32'h0;
    b.if_ready = 1'b0;
    auto_rsp = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b0;
    b.redirect_valid = 1'b0;
    b.redirect_pc = 32'h0;
    b.imem_gnt = 1'b0;
    b.imem_rvalid = 1'b0;
    b.imem_rdata = 32'h0;
    b.if_ready = 1'b0;
    #2;
    chk("rst_req", b.imem_req, 0);
    chk("rst_addr", b.imem_addr, 32'h0);
    chk("rst_valid", b.if_valid, 0);
    chk("rst_pc", b.if_pc, 32'h0);
    chk("rst_instr", b.if_instr, 32'h0);

    // Streaming: gnt=1, rvalid one cycle after grant, ready=1
    do_reset();
    b.imem_gnt = 1'b1; b.if_ready = 1'b1; auto_rsp = 1'b1; reset = 1'b1; #1;
    chk("stream_c0_req", b.imem_req, 1);
    chk("stream_c0_addr", b.imem_addr, 32'h0);
    tick();
    chk("stream_c1_addr", b.imem_addr, 32'h4);
    chk("stream_c1_valid", b.if_valid, 0);
    tick();
    chk("stream_c2_valid", b.if_valid, 1);
    chk("stream_c2_pc", b.if_pc, 32'h0);
    chk("stream_c2_instr", b.if_instr, ins(32'h0));
    tick();
    chk("stream_c3_pc", b.if_pc, 32'h4);
    tick();
    chk("stream_c4_pc", b.if_pc, 32'h8);
    chk("stream_c4_addr", b.imem_addr, 32'h10);

    // Back-pressure: ready=0 for 10 cycles, credit limit of 4
    do_reset();
    b.imem_gnt = 1'b1; auto_rsp = 1'b1; reset = 1'b1; n_issued = 0;
    repeat (10) tick();
    chk("bp_issued", n_issued, 4);
    chk("bp_req", b.imem_req, 0);
    chk("bp_valid", b.if_valid, 1);
    chk("bp_pc", b.if_pc, 32'h0);
    chk("bp_addr", b.imem_addr, 32'h10);

    // Pop one (3 left), then async reset mid-cycle
    b.imem_gnt = 1'b0; b.if_ready = 1'b1;
    tick();
    b.if_ready = 1'b0; auto_rsp = 1'b0;
    chk("pop1_pc", b.if_pc, 32'h4);
    #1 reset = 1'b0;
    #1;
    chk("async_req", b.imem_req, 0);
    chk("async_addr", b.imem_addr, 32'h0);
    chk("async_valid", b.if_valid, 0);
    chk("async_pc", b.if_pc, 32'h0);
    chk("async_instr", b.if_instr, 32'h0);
    tick();
    reset = 1'b1; b.imem_rvalid = 1'b1; b.imem_rdata = 32'hDEAD_BEEF; #1;
    chk("rel_req", b.imem_req, 1);
    chk("rel_addr", b.imem_addr, 32'h0);
    tick();
    b.imem_rvalid = 1'b0;
    chk("illegal_rsp_ignored", b.if_valid, 0);
    b.imem_gnt = 1'b1; auto_rsp = 1'b1;
    tick();
    tick();
    chk("restart_valid", b.if_valid, 1);
    chk("restart_pc", b.if_pc, 32'h0);
    chk("restart_instr", b.if_instr, ins(32'h0));

    // Redirect with 0x8 and 0xC outstanding
    do_reset();
    b.imem_gnt = 1'b1; b.if_ready = 1'b1; reset = 1'b1;
    tick();
    b.imem_rvalid = 1'b1; b.imem_rdata = ins(32'h0);
    tick();
    b.imem_rdata = ins(32'h4);
    tick();
    b.imem_rvalid = 1'b0; b.if_ready = 1'b0;
    tick();
    b.imem_gnt = 1'b0; b.redirect_valid = 1'b1; b.redirect_pc = 32'h100; #1;
    chk("redir_addr", b.imem_addr, 32'h100);
    chk("redir_pre_valid", b.if_valid, 1);
    chk("redir_pre_pc", b.if_pc, 32'h4);
    tick();
    b.redirect_valid = 1'b0; b.imem_gnt = 1'b1; b.imem_rvalid = 1'b1; b.imem_rdata = ins(32'h8);
    chk("redir_flush_valid", b.if_valid, 0);
    chk("redir_next_addr", b.imem_addr, 32'h100);
    tick();
    b.imem_rdata = ins(32'hC);
    chk("redir_drop8_valid", b.if_valid, 0);
    tick();
    b.imem_rdata = ins(32'h100); b.imem_gnt = 1'b0;
    chk("redir_dropC_valid", b.if_valid, 0);
    tick();
    b.imem_rvalid = 1'b0;
    chk("redir_new_valid", b.if_valid, 1);
    chk("redir_new_pc", b.if_pc, 32'h100);
    chk("redir_new_instr", b.if_instr, ins(32'h100));

    // Redirect to 0x203 with rvalid and gnt in the same cycle
    do_reset();
    b.imem_gnt = 1'b1; reset = 1'b1;
    tick();
    b.imem_rvalid = 1'b1; b.imem_rdata = ins(32'h0);
    b.redirect_valid = 1'b1; b.redirect_pc = 32'h203; #1;
    chk("same_addr", b.imem_addr, 32'h200);
    chk("same_req", b.imem_req, 1);
    tick();
    b.redirect_valid = 1'b0; b.imem_gnt = 1'b0; b.imem_rvalid = 1'b0;
    chk("same_next_addr", b.imem_addr, 32'h200);
    chk("same_rsp_dropped", b.if_valid, 0);
    tick();
    b.imem_rvalid = 1'b1; b.imem_rdata = 32'h1111_1111;
    tick();
    b.imem_rvalid = 1'b0; b.imem_gnt = 1'b1;
    chk("same_discard_dropped", b.if_valid, 0);
    tick();
    b.imem_gnt = 1'b0; b.imem_rvalid = 1'b1; b.imem_rdata = ins(32'h200);
    chk("same_refetch_addr", b.imem_addr, 32'h204);
    tick();
    b.imem_rvalid = 1'b0;
    chk("same_refetch_valid", b.if_valid, 1);
    chk("same_refetch_pc", b.if_pc, 32'h200);

    // Grant stall at 0xFFFF_FFFC, then wrap to 0x0
    do_reset();
    b.if_ready = 1'b1; reset = 1'b1;
    b.redirect_valid = 1'b1; b.redirect_pc = 32'hFFFF_FFFF; #1;
    chk("wrap_redir_addr", b.imem_addr, 32'hFFFF_FFFC);
    tick();
    b.redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_addr", b.imem_addr, 32'hFFFF_FFFC);
      chk("stall_req", b.imem_req, 1);
      tick();
    end
    b.imem_gnt = 1'b1;
    tick();
    b.imem_gnt = 1'b0; b.imem_rvalid = 1'b1; b.imem_rdata = ins(32'hFFFF_FFFC); #1;
    chk("wrap_addr", b.imem_addr, 32'h0);
    tick();
    b.imem_rvalid = 1'b0;
    chk("wrap_valid", b.if_valid, 1);
    chk("wrap_pc", b.if_pc, 32'hFFFF_FFFC);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
